nlc_section_sel: RTL and testbench
==================================

# nlc_section_sel

Front end of the ADC non-linearity corrector, directly upstream of `NLC`. It accepts raw signed 21-bit ADC samples and classifies each sample into one of four piecewise sections by threshold compare. It then drives `NLC` with the sample, that section's ten polynomial coefficients, negated mean and inverse std, and a one-cycle start strobe. It also holds those operands stable until `NLC` reports completion, and buffers one extra sample while `NLC` is busy.

## Interface
- TH_43, default -21'sd40000: x < TH_43 → section 4
- TH_32, default 21'sd20000: TH_43 ≤ x < TH_32 → section 3
- TH_21, default 21'sd50000: TH_32 ≤ x < TH_21 → section 2; x ≥ TH_21 → section 1
- TIMEOUT, default 1023: max BUSY cycles awaiting completion; 10-bit counter
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_x  in  21  signed (two's complement) ADC sample
- i_srdyi  in  1  sample valid, one-cycle strobe
- i_nlc_srdyo  in  1  completion strobe from `NLC` o_srdyo
- i_cfg_we  in  1  table write enable
- i_cfg_addr  in  6  [5:4] = section−1 (0..3), [3:0] = word: 0–9 coeffs1..10, 10 mean, 11 std; words 12–15 ignored
- i_cfg_data  in  32  IEEE-754 single word
- i_clr_flags  in  1  clears sticky flags
- o_x  out  21  sample to `NLC` i_x
- o_coeffs1 … o_coeffs10  out  32 each  to `NLC` i_coeffs1..10
- o_mean  out  32  negated mean to `NLC` i_mean
- o_std  out  32  inverse std to `NLC` i_std
- o_srdyo  out  1  start strobe to `NLC` i_srdyi
- o_section  out  2  issued section − 1
- o_busy  out  1  high in BUSY
- o_overflow  out  1  sticky: sample dropped
- o_timeout  out  1  sticky: completion never arrived

## Operation
- Table: 4×12×32 register file, written on any cycle with i_cfg_we. Reset clears it to 0.
- Classification: signed compares of i_x against the parameters, per the thresholds above.
- Issue: at the issuing edge, the block registers o_x, o_section, all coefficient, mean and std outputs from the table row at that edge, and sets o_srdyo=1 for exactly one cycle.
  - The registered outputs then hold until the next issue.
  - A table write on the same edge as an issue is not visible in that issue. The table is read before the write.
- FSM states: IDLE and BUSY.
  - IDLE, i_srdyi=1: issue i_x, then go to BUSY.
  - BUSY, cycle with o_srdyo=1: i_nlc_srdyo is ignored.
  - BUSY, otherwise, i_nlc_srdyo=1: if a pending sample is valid, issue it and stay in BUSY. If no sample is pending but i_srdyi=1 that cycle, issue i_x directly. Otherwise go to IDLE.
  - BUSY, i_srdyi=1 with no issue this edge: store the sample in the one-deep pending buffer if it is empty. If the buffer is full, drop the new sample and set o_overflow. The older sample is kept.
  - BUSY, TIMEOUT cycles after the issue with no completion: set o_timeout. Then issue the pending sample if one is valid, else go to IDLE.
- Completion resets the timeout counter. Each issue also reloads it to 0.
- Sticky flags: i_clr_flags clears them. If a set event and a clear occur on the same edge, set wins.

## Timing
- Latency is 1 cycle: i_srdyi sampled at edge k in IDLE gives o_srdyo=1 during cycle k→k+1, with operands valid in that same cycle.
- Back-to-back: completion sampled at edge j with a pending sample gives a new o_srdyo during cycle j→j+1.
- Reset values: all outputs 0, FSM in IDLE, pending buffer empty, counter 0.
- Reset takes effect mid-operation: the in-flight sample and the pending sample are discarded. A later i_nlc_srdyo that arrives in IDLE is ignored.
- i_srdyi held high for several cycles is treated as one sample per cycle.

## Test plan
- Load the four section rows via cfg, then drive x = −80000, 0, 40000, 60000, each waiting for completion. Required: o_section = 3, 2, 1, 0 respectively. The coefficient, mean and std outputs equal the loaded row. o_srdyo is high exactly 1 cycle after each i_srdyi.
- Boundary samples x = −40000, 19999, 20000, 50000. Required: sections 3, 3, 2, 1 (o_section 2, 2, 1, 0).
- While BUSY, send 2 samples (A then B) with no completion. Required: o_overflow=1 and B is dropped. On completion, A issues on the next cycle, and the block goes to IDLE after A completes.
- Completion and i_srdyi in the same BUSY cycle with the pending buffer empty. Required: the new sample issues on the next cycle with no IDLE gap.
- No completion is ever returned. Required: o_timeout=1 at 1023 cycles after the issue, and o_busy falls. Then i_clr_flags clears o_timeout.
- Reset asserted mid-BUSY with a pending sample. Required: all outputs 0 the next cycle. A following i_nlc_srdyo produces no issue.

Source files
------------

// File: rtl/nlc_section_sel.sv
// Front end of the ADC non-linearity corrector: classifies each sample into one of four
// sections, launches NLC with that section's coefficient row and buffers one sample while NLC is busy.
module nlc_section_sel #(
  parameter logic signed [20:0] TH_43   = -21'sd40000,
  parameter logic signed [20:0] TH_32   = 21'sd20000,
  parameter logic signed [20:0] TH_21   = 21'sd50000,
  parameter logic [9:0]         TIMEOUT = 10'd1023
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic signed [20:0] i_x,
  input  logic               i_srdyi,
  input  logic               i_nlc_srdyo,
  input  logic               i_cfg_we,
  input  logic [5:0]         i_cfg_addr,
  input  logic [31:0]        i_cfg_data,
  input  logic               i_clr_flags,
  output logic [20:0]        o_x,
  output logic [31:0]        o_coeffs1,
  output logic [31:0]        o_coeffs2,
  output logic [31:0]        o_coeffs3,
  output logic [31:0]        o_coeffs4,
  output logic [31:0]        o_coeffs5,
  output logic [31:0]        o_coeffs6,
  output logic [31:0]        o_coeffs7,
  output logic [31:0]        o_coeffs8,
  output logic [31:0]        o_coeffs9,
  output logic [31:0]        o_coeffs10,
  output logic [31:0]        o_mean,
  output logic [31:0]        o_std,
  output logic               o_srdyo,
  output logic [1:0]         o_section,
  output logic               o_busy,
  output logic               o_overflow,
  output logic               o_timeout
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t             state_q, state_d;
  logic               pend_vld_q, pend_vld_d;
  logic signed [20:0] pend_x_q, pend_x_d;
  logic [9:0]         cnt_q, cnt_d;
  logic signed [20:0] x_q, x_d;
  logic [1:0]         sec_q, sec_d;
  logic [31:0]        coef_q [10];
  logic [31:0]        coef_d [10];
  logic [31:0]        mean_q, mean_d;
  logic [31:0]        std_q, std_d;
  logic               srdyo_q, srdyo_d;
  logic               ovf_q, ovf_d;
  logic               tmo_q, tmo_d;
  logic [31:0]        tbl_q [4][12];
  logic [31:0]        tbl_d [4][12];

  logic               issue;
  logic signed [20:0] issue_x;
  logic [1:0]         issue_sec;
  logic               done;
  logic               timed_out;
  logic               ovf_set;
  logic               tmo_set;

  // Section index minus one: 3 for the most negative band, 0 for the top band.
  function automatic logic [1:0] sec_of(input logic signed [20:0] x);
    if (x < TH_43)      return 2'd3;
    else if (x < TH_32) return 2'd2;
    else if (x < TH_21) return 2'd1;
    else                return 2'd0;
  endfunction

  always_comb begin
    tbl_d = tbl_q;
    if (i_cfg_we && (i_cfg_addr[3:0] < 4'd12)) begin
      tbl_d[i_cfg_addr[5:4]][i_cfg_addr[3:0]] = i_cfg_data;
    end
  end

  // A completion in the same cycle as our own start strobe belongs to the previous job.
  assign done      = i_nlc_srdyo && !srdyo_q;
  assign timed_out = (cnt_q == (TIMEOUT - 10'd1));

  always_comb begin
    state_d    = state_q;
    pend_vld_d = pend_vld_q;
    pend_x_d   = pend_x_q;
    cnt_d      = cnt_q;
    issue      = 1'b0;
    issue_x    = i_x;
    ovf_set    = 1'b0;
    tmo_set    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (i_srdyi) begin
          issue   = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 10'd1;
        if (done || timed_out) begin
          tmo_set = !done;
          cnt_d   = '0;
          if (pend_vld_q) begin
            issue      = 1'b1;
            issue_x    = pend_x_q;
            pend_vld_d = i_srdyi;
            pend_x_d   = i_x;
          end else if (i_srdyi) begin
            issue = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (i_srdyi) begin
          if (!pend_vld_q) begin
            pend_vld_d = 1'b1;
            pend_x_d   = i_x;
          end else begin
            ovf_set = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign issue_sec = sec_of(issue_x);

  // Operands are captured from the pre-write table contents and held until the next issue.
  always_comb begin
    srdyo_d = issue;
    x_d     = issue ? issue_x : x_q;
    sec_d   = issue ? issue_sec : sec_q;
    for (int w = 0; w < 10; w++) begin
      coef_d[w] = issue ? tbl_q[issue_sec][w] : coef_q[w];
    end
    mean_d = issue ? tbl_q[issue_sec][10] : mean_q;
    std_d  = issue ? tbl_q[issue_sec][11] : std_q;
    ovf_d  = ovf_set | (ovf_q & ~i_clr_flags);
    tmo_d  = tmo_set | (tmo_q & ~i_clr_flags);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      pend_vld_q <= 1'b0;
      pend_x_q   <= '0;
      cnt_q      <= '0;
      x_q        <= '0;
      sec_q      <= '0;
      mean_q     <= '0;
      std_q      <= '0;
      srdyo_q    <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      for (int w = 0; w < 10; w++) begin
        coef_q[w] <= '0;
      end
      for (int s = 0; s < 4; s++) begin
        for (int w = 0; w < 12; w++) begin
          tbl_q[s][w] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_x_q   <= pend_x_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      sec_q      <= sec_d;
      mean_q     <= mean_d;
      std_q      <= std_d;
      srdyo_q    <= srdyo_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      coef_q     <= coef_d;
      tbl_q      <= tbl_d;
    end
  end

  assign o_x        = x_q;
  assign o_section  = sec_q;
  assign o_srdyo    = srdyo_q;
  assign o_busy     = (state_q == ST_BUSY);
  assign o_overflow = ovf_q;
  assign o_timeout  = tmo_q;
  assign o_mean     = mean_q;
  assign o_std      = std_q;
  assign o_coeffs1  = coef_q[0];
  assign o_coeffs2  = coef_q[1];
  assign o_coeffs3  = coef_q[2];
  assign o_coeffs4  = coef_q[3];
  assign o_coeffs5  = coef_q[4];
  assign o_coeffs6  = coef_q[5];
  assign o_coeffs7  = coef_q[6];
  assign o_coeffs8  = coef_q[7];
  assign o_coeffs9  = coef_q[8];
  assign o_coeffs10 = coef_q[9];

endmodule

// File: tb/tb_nlc_section_sel.sv
// Scoreboard bench for nlc_section_sel: expected issues are queued as samples are driven
// and compared whenever the block raises its start strobe.
module tb_nlc_section_sel;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [20:0] i_x;
  logic        i_srdyi;
  logic        i_nlc_srdyo;
  logic        i_cfg_we;
  logic [5:0]  i_cfg_addr;
  logic [31:0] i_cfg_data;
  logic        i_clr_flags;
  logic [20:0] o_x;
  logic [31:0] coef [10];
  logic [31:0] o_mean, o_std;
  logic        o_srdyo, o_busy, o_overflow, o_timeout;
  logic [1:0]  o_section;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [20:0] x;
    logic [1:0]  sec;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  nlc_section_sel dut (
    .i_clk(clk), .i_reset(i_reset), .i_x(i_x), .i_srdyi(i_srdyi),
    .i_nlc_srdyo(i_nlc_srdyo), .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr),
    .i_cfg_data(i_cfg_data), .i_clr_flags(i_clr_flags), .o_x(o_x),
    .o_coeffs1(coef[0]), .o_coeffs2(coef[1]), .o_coeffs3(coef[2]), .o_coeffs4(coef[3]),
    .o_coeffs5(coef[4]), .o_coeffs6(coef[5]), .o_coeffs7(coef[6]), .o_coeffs8(coef[7]),
    .o_coeffs9(coef[8]), .o_coeffs10(coef[9]), .o_mean(o_mean), .o_std(o_std),
    .o_srdyo(o_srdyo), .o_section(o_section), .o_busy(o_busy),
    .o_overflow(o_overflow), .o_timeout(o_timeout)
  );

  function automatic logic [31:0] tv(input int s, input int w);
    return 32'(32'h3F00_0007 + s * 32'h0001_0000 + w * 32'h0000_0101);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every start strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (o_srdyo) begin
      if (sb.size() == 0) begin
        check("unexpected_issue", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("issue x=%0d section=%0d", $signed(o_x), o_section);
        check("issue_x", 64'(o_x), 64'(e.x));
        check("issue_section", 64'(o_section), 64'(e.sec));
        for (int w = 0; w < 10; w++) check("issue_coeff", 64'(coef[w]), 64'(tv(int'(e.sec), w)));
        check("issue_mean", 64'(o_mean), 64'(tv(int'(e.sec), 10)));
        check("issue_std", 64'(o_std), 64'(tv(int'(e.sec), 11)));
      end
    end
  end

  task automatic pulse(input int x);
    @(posedge clk); #1;
    i_x = 21'(x); i_srdyi = 1'b1;
    @(posedge clk); #1;
    i_srdyi = 1'b0;
  endtask

  task automatic send(input int x, input int sec);
    exp_t e;
    e.x = 21'(x); e.sec = 2'(sec);
    sb.push_back(e);
    pulse(x);
    @(negedge clk);
    check("issue_latency", 64'(o_srdyo), 64'd1);
  endtask

  task automatic complete(input logic expect_issue);
    @(posedge clk); #1;
    i_nlc_srdyo = 1'b1;
    @(posedge clk); #1;
    i_nlc_srdyo = 1'b0;
    @(negedge clk);
    check("issue_after_completion", 64'(o_srdyo), 64'(expect_issue));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!o_busy) break;
      @(negedge clk);
    end
    check("return_to_idle", 64'(o_busy), 64'd0);
  endtask

  task automatic clear_flags();
    @(posedge clk); #1;
    i_clr_flags = 1'b1;
    @(posedge clk); #1;
    i_clr_flags = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int xs [8];
    int secs [8];
    exp_t e;
    xs   = '{-80000, 0, 40000, 60000, -40000, 19999, 20000, 50000};
    secs = '{3, 2, 1, 0, 2, 2, 1, 0};
    i_reset = 1'b1; i_x = '0; i_srdyi = 1'b0; i_nlc_srdyo = 1'b0;
    i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_data = '0; i_clr_flags = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    check("reset_srdyo", 64'(o_srdyo), 64'd0);
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_x", 64'(o_x), 64'd0);
    check("reset_coeff1", 64'(coef[0]), 64'd0);
    check("reset_flags", 64'({o_overflow, o_timeout}), 64'd0);

    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < 12; w++) begin
        @(posedge clk); #1;
        i_cfg_we = 1'b1; i_cfg_addr = {2'(s), 4'(w)}; i_cfg_data = tv(s, w);
      end
    end
    @(posedge clk); #1 i_cfg_we = 1'b0;

    // Section classification, including the threshold boundaries.
    for (int i = 0; i < 8; i++) begin
      send(xs[i], secs[i]);
      check("busy_after_issue", 64'(o_busy), 64'd1);
      complete(1'b0);
      wait_idle();
    end

    // Pending buffer: A is held, B overflows and is dropped.
    send(-100000, 3);
    e.x = 21'(30000); e.sec = 2'd1; sb.push_back(e);
    pulse(30000);
    @(negedge clk);
    check("no_overflow_yet", 64'(o_overflow), 64'd0);
    pulse(70000);
    @(negedge clk);
    check("overflow_set", 64'(o_overflow), 64'd1);
    complete(1'b1);
    check("busy_with_pending", 64'(o_busy), 64'd1);
    complete(1'b0);
    wait_idle();
    clear_flags();
    check("overflow_cleared", 64'(o_overflow), 64'd0);

    // Completion and a new sample in the same cycle: direct issue with no idle gap.
    send(10, 2);
    e.x = 21'(55555); e.sec = 2'd0; sb.push_back(e);
    @(posedge clk); #1;
    i_nlc_srdyo = 1'b1; i_srdyi = 1'b1; i_x = 21'(55555);
    @(posedge clk); #1;
    i_nlc_srdyo = 1'b0; i_srdyi = 1'b0;
    @(negedge clk);
    check("direct_issue", 64'(o_srdyo), 64'd1);
    check("direct_issue_busy", 64'(o_busy), 64'd1);
    complete(1'b0);
    wait_idle();

    // Completion never arrives.
    send(-1, 2);
    repeat (1022) @(negedge clk);
    check("timeout_not_early", 64'(o_timeout), 64'd0);
    check("busy_before_timeout", 64'(o_busy), 64'd1);
    @(negedge clk);
    check("timeout_set", 64'(o_timeout), 64'd1);
    check("idle_after_timeout", 64'(o_busy), 64'd0);
    clear_flags();
    check("timeout_cleared", 64'(o_timeout), 64'd0);

    // Reset while busy with a pending sample.
    send(-50000, 3);
    pulse(1234);
    @(posedge clk); #1 i_reset = 1'b1;
    @(posedge clk); #1 i_reset = 1'b0;
    @(negedge clk);
    check("midreset_busy", 64'(o_busy), 64'd0);
    check("midreset_x", 64'(o_x), 64'd0);
    check("midreset_section", 64'(o_section), 64'd0);
    check("midreset_coeff10", 64'(coef[9]), 64'd0);
    check("midreset_std", 64'(o_std), 64'd0);
    complete(1'b0);
    check("stray_completion_idle", 64'(o_busy), 64'd0);
    repeat (3) @(negedge clk);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
